// File: rtl/cronometru_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cronometru_ctrl
//  Brief    : Run/stop/lap/clear sequencer with debounced buttons for the
//             Cronometru 4-digit BCD stopwatch.
//  Revision : 1.0
// ============================================================================
module cronometru_ctrl #(
    parameter int DB_CYCLES  = 16,
    parameter int DB_W       = 5,
    parameter int RST_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_ss_i,
    input  logic       btn_lr_i,
    input  logic [3:0] bcd0_i,
    input  logic [3:0] bcd1_i,
    input  logic [3:0] bcd2_i,
    input  logic [3:0] bcd3_i,
    input  logic       carry_i,
    output logic       sw_pause_o,
    output logic       sw_reset_o,
    output logic [3:0] disp0_o,
    output logic [3:0] disp1_o,
    output logic [3:0] disp2_o,
    output logic [3:0] disp3_o,
    output logic       running_o,
    output logic       lap_active_o,
    output logic       ovf_o
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_LAP   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [1:0] w_btn;
    logic [1:0] w_press;

    assign w_btn = {btn_lr_i, btn_ss_i};

    // Index 0 is start/stop, index 1 is lap/reset.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            db_q;
        logic            press_q;
        logic [DB_W-1:0] cnt_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                db_q    <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= w_btn[b];
                sync2_q <= sync1_q;
                press_q <= 1'b0;
                if (sync2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    db_q    <= sync2_q;
                    press_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end
        end

        assign w_press[b] = press_q;
    end

    state_t          state_q;
    state_t          state_d;
    logic [RC_W-1:0] rcnt_q;
    logic [15:0]     lap_q;
    logic            ovf_q;
    logic            sw_pause_q;
    logic            sw_reset_q;
    logic            running_q;
    logic            lap_active_q;
    logic            w_live;

    assign w_live = (state_q == S_RUN) || (state_q == S_LAP);

    // Carry outranks both presses; start/stop outranks lap/reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (rcnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_IDLE;
            S_IDLE:  if (w_press[0]) state_d = S_RUN;
            S_RUN: begin
                if (carry_i || w_press[0]) state_d = S_STOP;
                else if (w_press[1])       state_d = S_LAP;
            end
            S_LAP: begin
                if (carry_i || w_press[0]) state_d = S_STOP;
                else if (w_press[1])       state_d = S_RUN;
            end
            S_STOP: begin
                if (w_press[0])      state_d = S_RUN;
                else if (w_press[1]) state_d = S_CLEAR;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_CLEAR;
            rcnt_q       <= '0;
            lap_q        <= '0;
            ovf_q        <= 1'b0;
            sw_pause_q   <= 1'b1;
            sw_reset_q   <= 1'b1;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= ((state_q == S_CLEAR) && (state_d == S_CLEAR)) ? rcnt_q + RC_W'(1) : '0;
            if (w_live && carry_i)
                ovf_q <= 1'b1;
            else if ((state_d == S_CLEAR) && (state_q != S_CLEAR))
                ovf_q <= 1'b0;
            if ((state_q == S_RUN) && (state_d == S_LAP))
                lap_q <= {bcd3_i, bcd2_i, bcd1_i, bcd0_i};
            sw_pause_q   <= !((state_d == S_RUN) || (state_d == S_LAP));
            sw_reset_q   <= (state_d == S_CLEAR);
            running_q    <= (state_d == S_RUN) || (state_d == S_LAP);
            lap_active_q <= (state_d == S_LAP);
        end
    end

    assign sw_pause_o   = sw_pause_q;
    assign sw_reset_o   = sw_reset_q;
    assign running_o    = running_q;
    assign lap_active_o = lap_active_q;
    assign ovf_o        = ovf_q;
    assign {disp3_o, disp2_o, disp1_o, disp0_o} =
        lap_active_q ? lap_q : {bcd3_i, bcd2_i, bcd1_i, bcd0_i};

endmodule
`default_nettype wire

// File: tb/tb_cronometru_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cronometru_ctrl
//  Brief    : Scoreboard bench for cronometru_ctrl against a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_cronometru_ctrl;

    localparam int DB_CYCLES  = 4;
    localparam int DB_W       = 3;
    localparam int RST_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_ss = 1'b0, btn_lr = 1'b0, carry = 1'b0;
    logic [3:0] bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0;
    logic       sw_pause, sw_reset, running, lap_active, ovf;
    logic [3:0] disp0, disp1, disp2, disp3;

    cronometru_ctrl #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk_i(clk), .reset_i(reset), .btn_ss_i(btn_ss), .btn_lr_i(btn_lr),
        .bcd0_i(bcd0), .bcd1_i(bcd1), .bcd2_i(bcd2), .bcd3_i(bcd3), .carry_i(carry),
        .sw_pause_o(sw_pause), .sw_reset_o(sw_reset),
        .disp0_o(disp0), .disp1_o(disp1), .disp2_o(disp2), .disp3_o(disp3),
        .running_o(running), .lap_active_o(lap_active), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    typedef enum {M_CLEAR, M_IDLE, M_RUN, M_LAP, M_STOP} mstate_t;
    mstate_t     m_st;
    int          m_clr_elapsed;
    bit          m_ovf;
    logic [15:0] m_lap;
    bit          dl_ss[$], dl_lr[$];
    int          streak_ss, streak_lr;
    bit          db_ss, db_lr, pulse_ss, pulse_lr;

    function automatic void model_reset();
        m_st = M_CLEAR; m_clr_elapsed = 0; m_ovf = 0; m_lap = '0;
        dl_ss.delete(); dl_ss.push_back(0); dl_ss.push_back(0);
        dl_lr.delete(); dl_lr.push_back(0); dl_lr.push_back(0);
        streak_ss = 0; streak_lr = 0; db_ss = 0; db_lr = 0; pulse_ss = 0; pulse_lr = 0;
    endfunction

    // A level is accepted once it has disagreed with the debounced level DB_CYCLES times in a row.
    task automatic db_step(input bit syn, inout int streak, inout bit db, output bit pulse);
        pulse = 0;
        if (syn == db) streak = 0;
        else begin
            streak++;
            if (streak == DB_CYCLES) begin
                db = syn; streak = 0; pulse = syn;
            end
        end
    endtask

    task automatic model_edge(input bit raw_ss, input bit raw_lr, input bit car, input logic [15:0] bcd);
        bit p_ss, p_lr, syn;
        p_ss = pulse_ss; p_lr = pulse_lr;
        syn = dl_ss.pop_front(); dl_ss.push_back(raw_ss);
        db_step(syn, streak_ss, db_ss, pulse_ss);
        syn = dl_lr.pop_front(); dl_lr.push_back(raw_lr);
        db_step(syn, streak_lr, db_lr, pulse_lr);
        case (m_st)
            M_CLEAR: begin
                m_clr_elapsed++;
                if (m_clr_elapsed >= RST_CYCLES) m_st = M_IDLE;
            end
            M_IDLE: if (p_ss) m_st = M_RUN;
            M_RUN, M_LAP: begin
                if (car) begin m_ovf = 1; m_st = M_STOP; end
                else if (p_ss) m_st = M_STOP;
                else if (p_lr) begin
                    if (m_st == M_RUN) begin m_lap = bcd; m_st = M_LAP; end
                    else m_st = M_RUN;
                end
            end
            M_STOP: begin
                if (p_ss) m_st = M_RUN;
                else if (p_lr) begin m_st = M_CLEAR; m_clr_elapsed = 0; m_ovf = 0; end
            end
            default: m_st = M_CLEAR;
        endcase
    endtask

    // ---------------- driver ----------------
    logic [20:0] exp_q[$];
    logic [15:0] cur_bcd = '0;
    bit cur_ss = 0, cur_lr = 0, cur_car = 0, cur_rst = 1, adv = 0;

    task automatic step();
        logic [20:0] e;
        bit live;
        @(negedge clk);
        if (adv) cur_bcd = {4'($urandom_range(9)), 4'($urandom_range(9)),
                            4'($urandom_range(9)), 4'($urandom_range(9))};
        reset = cur_rst; btn_ss = cur_ss; btn_lr = cur_lr; carry = cur_car;
        {bcd3, bcd2, bcd1, bcd0} = cur_bcd;
        if (cur_rst) model_reset();
        else model_edge(cur_ss, cur_lr, cur_car, cur_bcd);
        live = (m_st == M_RUN) || (m_st == M_LAP);
        e = {!live, m_st == M_CLEAR, live, m_st == M_LAP, m_ovf,
             (m_st == M_LAP) ? m_lap : cur_bcd};
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit ss, input bit lr, input int len);
        cur_ss = ss; cur_lr = lr;
        hold(len);
        cur_ss = 0; cur_lr = 0;
        hold(9);
    endtask

    task automatic pulse_carry();
        cur_car = 1; step(); cur_car = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [20:0] e, a;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {sw_pause, sw_reset, running, lap_active, ovf, disp3, disp2, disp1, disp0};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got pause/rst/run/lap/ovf/disp=%b%b%b%b%b/%h expected %b%b%b%b%b/%h",
                             $time, a[20], a[19], a[18], a[17], a[16], a[15:0],
                             e[20], e[19], e[18], e[17], e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        cur_rst = 1; hold(3);
        cur_rst = 0; hold(4);

        press(1, 0, 10);               // start
        press(1, 0, 3);                // too short, ignored
        cur_bcd = 16'h4321;
        press(0, 1, 6);                // lap
        adv = 1; hold(10);
        press(0, 1, 6);                // back to live
        adv = 0;
        pulse_carry(); hold(2);        // overflow stop
        press(0, 1, 6);                // clear
        hold(3);
        press(1, 0, 6);
        press(1, 1, 6);                // coincident presses: stop wins
        press(1, 0, 6);
        press(0, 1, 6);                // in LAP
        adv = 1; hold(3);
        cur_rst = 1; cur_ss = 1; step();
        #1;
        checks++;
        if (sw_reset !== 1'b1 || lap_active !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got sw_reset=%b lap_active=%b expected 1 0", sw_reset, lap_active);
        end
        hold(2);
        cur_rst = 0; hold(5);          // button still held across reset
        cur_ss = 0; hold(8);
        press(1, 0, 6);
        press(0, 1, 6);

        repeat (160) begin
            int sel;
            sel = $urandom_range(0, 19);
            adv = $urandom_range(0, 1) != 0;
            if (sel < 7)       press(1, 0, $urandom_range(1, 8));
            else if (sel < 13) press(0, 1, $urandom_range(1, 8));
            else if (sel < 15) press(1, 1, $urandom_range(2, 7));
            else if (sel < 18) pulse_carry();
            else if (sel < 19) begin
                cur_rst = 1; hold($urandom_range(1, 3)); cur_rst = 0;
            end else begin
                cur_ss = 1; hold($urandom_range(1, 4)); cur_lr = 1; cur_ss = 0;
                hold($urandom_range(1, 5)); cur_lr = 0;
            end
            hold($urandom_range(0, 6));
        end

        @(posedge clk); #2;
        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
